// File: rtl/axi_pkg.sv
// Shared AXI-Lite definitions: response codes, master FSM encoding and the
// default bus geometry used by both the master and the coprocessor slave.
package axi_pkg;

  localparam int AXI_ADDR_W = 5;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } master_state_e;

endpackage

// File: rtl/axi_wait_timer.sv
// Saturating wait-state counter: expired_o flags the LIMIT-th enabled cycle
// since the last clear. Only used when AXI_MASTER_TIMEOUT_EN is defined.
module axi_wait_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int               CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command in, one AXI-Lite transaction out, one
// response back. Optional wait-state timeout under AXI_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_pkg::*;
#(
  parameter int ADDR_W         = AXI_ADDR_W,
  parameter int DATA_W         = AXI_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                m_axi_aclk,
  input  logic                m_axi_aresetn,
  // command / response side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  // write address / data / response channels
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // read address / data channels
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  master_state_e       state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic aw_hs, w_hs, aw_done, w_done;
  logic in_wait, timeout;

  assign aw_hs   = awvalid_q && m_axi_awready;
  assign w_hs    = wvalid_q && m_axi_wready;
  // A channel's valid register doubles as its "still outstanding" flag.
  assign aw_done = aw_hs || !awvalid_q;
  assign w_done  = w_hs || !wvalid_q;

  assign in_wait = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

`ifdef AXI_MASTER_TIMEOUT_EN
  axi_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .clear_i   (state_d != state_q),
    .enable_i  (in_wait),
    .expired_o (timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_in_wait;
  assign unused_in_wait = in_wait;
  assign timeout        = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done && w_done) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Recovery path: abandon the bus transaction and report DECERR.
    if (timeout) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      rdata_d   = '0;
      resp_d    = RESP_DECERR;
      state_d   = ST_RSP;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master; the timeout step runs only when
// AXI_MASTER_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 16).
module tb_axi_lite_master;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid, wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0, bready;
  logic          arvalid, arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0, rready;

  int errors = 0;
  int checks = 0;
  int aw_beats = 0;
  int w_beats = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  // Count accepted AW and W beats to catch duplicated transfers.
  always @(posedge clk) begin
    if (rst_n && awvalid && awready) aw_beats <= aw_beats + 1;
    if (rst_n && wvalid && wready)   w_beats  <= w_beats + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag, input int max_cycles);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int n;
    int aw0, w0;

    // ---------------- reset values
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("rst_awaddr", {27'd0, awaddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // ---------------- write with always-ready slave
    awready = 1'b1; wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd12; cmd_wdata = 32'd123; cmd_wstrb = 4'hF;
    chk("w1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("w1_valids_c1", {30'd0, awvalid, wvalid}, 32'd3);
    chk("w1_awaddr", {27'd0, awaddr}, 32'd12);
    chk("w1_wdata", wdata, 32'd123);
    chk("w1_wstrb", {28'd0, wstrb}, 32'hF);
    chk("w1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("w1_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
    chk("w1_bready", {31'd0, bready}, 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("w1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("w1_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_bready_off", {31'd0, bready}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w1_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    awready = 1'b0; wready = 1'b0;

    // ---------------- read with 3-cycle AR stall
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd13;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r1_arvalid_stall", {31'd0, arvalid}, 32'd1);
      chk("r1_araddr_stall", {27'd0, araddr}, 32'd13);
      if (i < 2) step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r1_arvalid_drop", {31'd0, arvalid}, 32'd0);
    chk("r1_rready", {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata = 32'd1234; rresp = 2'b00;
    step();
    rvalid = 1'b0; rdata = '0;
    chk("r1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("r1_rsp_rdata", rsp_rdata, 32'd1234);
    chk("r1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r1_idle", {31'd0, cmd_ready}, 32'd1);

    // ---------------- split write channels: W ready two cycles before AW
    aw0 = aw_beats; w0 = w_beats;
    wready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd3; cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'h3;
    step();
    cmd_valid = 1'b0;
    chk("sp_valids_c1", {30'd0, awvalid, wvalid}, 32'd3);
    step();
    chk("sp_w_done_aw_wait", {30'd0, awvalid, wvalid}, 32'd2);
    step();
    chk("sp_aw_still", {30'd0, awvalid, wvalid}, 32'd2);
    chk("sp_awaddr_stable", {27'd0, awaddr}, 32'd3);
    awready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("sp_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
    chk("sp_bready", {31'd0, bready}, 32'd1);
    chk("sp_aw_beats", aw_beats - aw0, 32'd1);
    chk("sp_w_beats", w_beats - w0, 32'd1);
    rsp_ready = 1'b1;
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("sp_rsp", {29'd0, rsp_valid, rsp_resp}, 32'h4);
    step();
    rsp_ready = 1'b0;
    chk("sp_idle", {31'd0, cmd_ready}, 32'd1);

    // ---------------- read SLVERR with response backpressure
    arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd7;
    step();
    cmd_valid = 1'b0;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    step();
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_resp", {30'd0, rsp_resp}, 32'd2);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_cmd_ready_same", {31'd0, cmd_ready}, 32'd0);
    step();
    rsp_ready = 1'b0;
    chk("bp_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);

    // ---------------- asynchronous reset in the middle of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd9; cmd_wdata = 32'd99; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    chk("mr_awvalid_pre", {31'd0, awvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valids_async", {30'd0, awvalid, wvalid}, 32'd0);
    chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    arready = 1'b1; rvalid = 1'b1; rdata = 32'd55; rresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5;
    step();
    cmd_valid = 1'b0;
    chk("mr_araddr", {27'd0, araddr}, 32'd5);
    wait_rsp("mr_rsp_wait", 10);
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    chk("mr_rsp_rdata", rsp_rdata, 32'd55);
    chk("mr_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("mr_idle", {31'd0, cmd_ready}, 32'd1);

`ifdef AXI_MASTER_TIMEOUT_EN
    // ---------------- timeout: AR never accepted
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (arvalid && n < 40) begin
      n++;
      step();
    end
    chk("to_arvalid_cycles", n, 32'd16);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_resp", {30'd0, rsp_resp}, 32'd3);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_idle", {31'd0, cmd_ready}, 32'd1);
`else
    n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
